// File: rtl/imem_loader.sv
// imem_loader: fills instruction memory from a byte stream.
//
// The stream is a 2-byte big-endian word count followed by that many
// big-endian 32-bit instruction words. Each word is written to
// BASE_ADDR + 4*index. The CPU is held stopped (cpu_run=0) until the last
// word has been written.
//
// Ports:
//   CLK, RST_N            clock, synchronous active-low reset
//   start                 one-cycle request to begin a load (IDLE/DONE/ERR only)
//   rx_data/valid/ready   byte stream handshake; transfer on valid && ready
//   imem_we/addr/wdata    instruction-memory write port, one strobe per word
//   busy, done, err       load status; cpu_run mirrors done
module imem_loader #(
    parameter int          DEPTH     = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        cpu_run
);

    typedef enum logic [2:0] {
        IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE, ERR
    } state_t;

    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    state_t      state;
    logic [15:0] len;
    logic [15:0] word_cnt;
    logic [1:0]  byte_cnt;
    logic [23:0] asm_word;   // first three bytes of the word in progress

    logic        xfer;
    logic [15:0] full_len;
    logic [15:0] next_cnt;
    logic [31:0] word_addr;

    assign xfer      = rx_valid && rx_ready;
    assign full_len  = {len[15:8], rx_data};
    assign next_cnt  = word_cnt + 16'd1;
    assign word_addr = BASE_ADDR + {14'd0, word_cnt, 2'b00};

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state      <= IDLE;
            rx_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= BASE_ADDR;
            imem_wdata <= 32'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            cpu_run    <= 1'b0;
            len        <= 16'd0;
            word_cnt   <= 16'd0;
            byte_cnt   <= 2'd0;
            asm_word   <= 24'd0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                // IDLE, DONE and ERR are the only states that honour start.
                IDLE, DONE, ERR: begin
                    rx_ready <= 1'b0;
                    if (start) begin
                        state    <= LEN_HI;
                        rx_ready <= 1'b1;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        err      <= 1'b0;
                        cpu_run  <= 1'b0;
                        len      <= 16'd0;
                        word_cnt <= 16'd0;
                        byte_cnt <= 2'd0;
                    end
                end
                LEN_HI: begin
                    if (xfer) begin
                        len[15:8] <= rx_data;
                        state     <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (xfer) begin
                        len[7:0] <= rx_data;
                        if (full_len == 16'd0 || {16'd0, full_len} > DEPTH_W) begin
                            state    <= ERR;
                            rx_ready <= 1'b0;
                            busy     <= 1'b0;
                            err      <= 1'b1;
                        end else begin
                            state    <= DATA;
                            byte_cnt <= 2'd0;
                            word_cnt <= 16'd0;
                        end
                    end
                end
                DATA: begin
                    if (xfer) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        asm_word <= {asm_word[15:0], rx_data};
                        // Fourth byte completes the word: issue the write
                        // directly from the assembly register plus this byte.
                        if (byte_cnt == 2'd3) begin
                            state      <= WRITE;
                            rx_ready   <= 1'b0;
                            imem_we    <= 1'b1;
                            imem_wdata <= {asm_word, rx_data};
                            imem_addr  <= word_addr;
                        end
                    end
                end
                WRITE: begin
                    word_cnt <= next_cnt;
                    byte_cnt <= 2'd0;
                    if (next_cnt == len) begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        cpu_run <= 1'b1;
                    end else begin
                        state    <= DATA;
                        rx_ready <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    rx_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        RST_N, start, rx_valid;
    logic [7:0]  rx_data;

    logic        r0, we0, busy0, done0, err0, run0;
    logic [31:0] addr0, wd0;
    logic        r1, we1, busy1, done1, err1, run1;
    logic [31:0] addr1, wd1;

    localparam logic [31:0] BASE1 = 32'h0000_0100;

    imem_loader #(.DEPTH(64), .BASE_ADDR(32'h0)) dut0 (
        .CLK(CLK), .RST_N(RST_N), .start(start), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_ready(r0), .imem_we(we0), .imem_addr(addr0),
        .imem_wdata(wd0), .busy(busy0), .done(done0), .err(err0), .cpu_run(run0));

    imem_loader #(.DEPTH(64), .BASE_ADDR(BASE1)) dut1 (
        .CLK(CLK), .RST_N(RST_N), .start(start), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_ready(r1), .imem_we(we1), .imem_addr(addr1),
        .imem_wdata(wd1), .busy(busy1), .done(done1), .err(err1), .cpu_run(run1));

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t q0[$];
    wr_t q1[$];

    typedef struct {
        int               n;
        logic [0:15][7:0] b;
        int               gap;
        bit               exp_done;
        bit               exp_err;
    } vec_t;

    vec_t tbl[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the oldest expected write.
    always @(negedge CLK) begin
        wr_t e;
        if (we0 === 1'b1) begin
            if (q0.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_write0: addr %h data %h, required no write", addr0, wd0);
            end else begin
                e = q0.pop_front();
                check("wr0_addr", addr0, e.addr);
                check("wr0_data", wd0, e.data);
            end
        end
        if (we1 === 1'b1) begin
            if (q1.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_write1: addr %h data %h, required no write", addr1, wd1);
            end else begin
                e = q1.pop_front();
                check("wr1_addr", addr1, e.addr);
                check("wr1_data", wd1, e.data);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the byte was taken.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        rx_data  = b;
        rx_valid = 1'b1;
        t = 0;
        while (r0 !== 1'b1 && t < 64) begin
            @(negedge CLK);
            t++;
        end
        if (r0 !== 1'b1) begin
            tests++; fails++;
            $display("FAIL rx_timeout: rx_ready %b, required 1", r0);
        end
        @(negedge CLK);
        rx_valid = 1'b0;
        repeat (gap) @(negedge CLK);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
    endtask

    task automatic push_word(input int idx, input logic [31:0] w);
        q0.push_back('{addr: 32'(idx) * 32'd4, data: w});
        q1.push_back('{addr: BASE1 + 32'(idx) * 32'd4, data: w});
    endtask

    task automatic check_reset();
        check("rst_ready", {31'd0, r0}, 32'd0);
        check("rst_we", {31'd0, we0}, 32'd0);
        check("rst_addr0", addr0, 32'd0);
        check("rst_addr1", addr1, BASE1);
        check("rst_wdata", wd0, 32'd0);
        check("rst_busy", {31'd0, busy0}, 32'd0);
        check("rst_done", {31'd0, done0}, 32'd0);
        check("rst_err", {31'd0, err0}, 32'd0);
        check("rst_run", {31'd0, run0 | run1}, 32'd0);
    endtask

    task automatic run_vec(input vec_t v, input int k);
        logic [15:0] len;
        bit ok;
        pulse_start();
        check($sformatf("v%0d_busy_start", k), {31'd0, busy0}, 32'd1);
        len = {v.b[0], v.b[1]};
        ok  = (len != 16'd0) && (len <= 16'd64);
        for (int i = 0; i < v.n; i++) begin
            if (ok && i >= 5 && ((i - 2) % 4) == 3)
                push_word((i - 2) / 4, {v.b[i-3], v.b[i-2], v.b[i-1], v.b[i]});
            send_byte(v.b[i], (i == v.n - 1) ? 0 : v.gap);
        end
        // Last word is being written this cycle; done follows one cycle later.
        if (v.exp_done) begin
            check($sformatf("v%0d_done_early", k), {31'd0, done0}, 32'd0);
            check($sformatf("v%0d_we_last", k), {31'd0, we0}, 32'd1);
        end
        @(negedge CLK);
        check($sformatf("v%0d_done", k), {31'd0, done0}, {31'd0, v.exp_done});
        check($sformatf("v%0d_run", k), {31'd0, run1}, {31'd0, v.exp_done});
        check($sformatf("v%0d_err", k), {31'd0, err0}, {31'd0, v.exp_err});
        check($sformatf("v%0d_busy", k), {31'd0, busy0}, 32'd0);
    endtask

    initial begin
        tbl[0] = '{n: 10, b: 128'h0002_2008_0005_AC08_0004_0000_0000_0000, gap: 0, exp_done: 1, exp_err: 0};
        tbl[1] = '{n: 10, b: 128'h0002_2008_0005_AC08_0004_0000_0000_0000, gap: 3, exp_done: 1, exp_err: 0};
        tbl[2] = '{n: 2,  b: 128'h0000_0000_0000_0000_0000_0000_0000_0000, gap: 0, exp_done: 0, exp_err: 1};
        tbl[3] = '{n: 2,  b: 128'h0041_0000_0000_0000_0000_0000_0000_0000, gap: 0, exp_done: 0, exp_err: 1};
        tbl[4] = '{n: 14, b: 128'h0003_1122_3344_5566_7788_99AA_BBCC_0000, gap: 1, exp_done: 1, exp_err: 0};

        RST_N = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (3) @(negedge CLK);
        check_reset();
        RST_N = 1'b1;
        @(negedge CLK);

        for (int k = 0; k < 5; k++) run_vec(tbl[k], k);

        // start pulsed mid-word is ignored.
        pulse_start();
        send_byte(8'h00, 0); send_byte(8'h01, 0);
        send_byte(8'h01, 0); send_byte(8'h02, 0);
        pulse_start();
        check("start_in_data_busy", {31'd0, busy0}, 32'd1);
        send_byte(8'h03, 0);
        push_word(0, 32'h0102_0304);
        send_byte(8'h04, 0);
        @(negedge CLK);
        check("start_in_data_done", {31'd0, done0}, 32'd1);

        // Extra byte in DONE is refused; start in DONE restarts from base.
        rx_valid = 1'b1; rx_data = 8'hFF;
        @(negedge CLK);
        check("done_refuses_byte", {31'd0, r0}, 32'd0);
        rx_valid = 1'b0;
        pulse_start();
        check("restart_run", {31'd0, run0}, 32'd0);
        check("restart_done", {31'd0, done1}, 32'd0);
        send_byte(8'h00, 0); send_byte(8'h01, 0);
        send_byte(8'hCA, 0); send_byte(8'hFE, 0); send_byte(8'hF0, 0);
        push_word(0, 32'hCAFE_F00D);
        send_byte(8'h0D, 0);
        @(negedge CLK);
        check("restart_done_end", {31'd0, done0 & done1}, 32'd1);

        // Reset mid-word discards the partial word.
        pulse_start();
        send_byte(8'h00, 0); send_byte(8'h01, 0);
        send_byte(8'h12, 0); send_byte(8'h34, 0);
        RST_N = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        check_reset();
        rx_valid = 1'b1; rx_data = 8'h56;
        repeat (2) @(negedge CLK);
        rx_data = 8'h78;
        repeat (2) @(negedge CLK);
        check("post_rst_ready", {31'd0, r0}, 32'd0);
        rx_valid = 1'b0;
        pulse_start();
        send_byte(8'h00, 0); send_byte(8'h01, 0);
        send_byte(8'hDE, 0); send_byte(8'hAD, 0); send_byte(8'hBE, 0);
        push_word(0, 32'hDEAD_BEEF);
        send_byte(8'hEF, 0);
        @(negedge CLK);
        check("post_rst_done", {31'd0, run0}, 32'd1);

        repeat (2) @(negedge CLK);
        check("q0_empty", 32'(q0.size()), 32'd0);
        check("q1_empty", 32'(q1.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction-memory interface. The datapath only reads instruction memory through PC-addressed fetch; this block fills it.
- Receives a byte stream over a valid/ready handshake: a 2-byte length header, then N big-endian 32-bit instruction words.
- Writes each word into instruction memory at consecutive word-aligned byte addresses.
- Holds the CPU stopped (cpu_run=0) until the load completes.

Parameters:
- DEPTH, 64, maximum number of instruction words the memory holds.
- BASE_ADDR, 32'h0000_0000, byte address of the first word written; must be a multiple of 4.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST_N  input  1  synchronous active-low reset.
- start  input  1  one-cycle request to begin a load.
- rx_data  input  8  incoming byte.
- rx_valid  input  1  rx_data is valid.
- rx_ready  output  1  loader accepts a byte this cycle; transfer occurs when rx_valid&&rx_ready at the rising edge.
- imem_we  output  1  instruction-memory write strobe, one cycle per word.
- imem_addr  output  32  byte address of the write (BASE_ADDR + 4*index).
- imem_wdata  output  32  instruction word to write.
- busy  output  1  load in progress.
- done  output  1  last load completed successfully.
- err  output  1  last load rejected (bad length).
- cpu_run  output  1  CPU may execute; equals done.

Behaviour:
- All outputs are registered.
- Synchronous reset (RST_N=0 at an edge) sets:
  - state=IDLE, rx_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0;
  - busy=0, done=0, err=0, cpu_run=0;
  - word counter, byte counter and length all 0.
- Reset wins over every other input.
- Reset in mid-load discards any partial word; no write is issued.
- States:
  - IDLE:
    - rx_ready=0.
    - start=1 -> LEN_HI; busy=1, done=0, err=0, cpu_run=0.
  - LEN_HI:
    - rx_ready=1.
    - On a transfer, len[15:8]=rx_data, then -> LEN_LO.
  - LEN_LO:
    - rx_ready=1.
    - On a transfer, len[7:0]=rx_data.
    - If the full 16-bit len is 0 or len>DEPTH -> ERR.
    - Otherwise -> DATA with byte_cnt=0, word_cnt=0.
  - DATA:
    - rx_ready=1.
    - Each transfer shifts the byte into the assembly register big-endian: the first byte lands in [31:24], the fourth in [7:0].
    - On the 4th byte -> WRITE.
    - rx_valid=0 stalls the state with no change; gaps of any length are allowed.
  - WRITE (exactly one cycle):
    - imem_we=1, imem_wdata=assembled word, imem_addr=BASE_ADDR+4*word_cnt.
    - rx_ready=0.
    - Next edge: word_cnt+1; if word_cnt+1==len -> DONE, else -> DATA.
  - DONE:
    - busy=0, done=1, cpu_run=1, rx_ready=0; held indefinitely.
    - start=1 -> LEN_HI with done/cpu_run cleared at that edge.
  - ERR:
    - busy=0, err=1, cpu_run=0, rx_ready=0; no memory write has occurred.
    - start=1 -> LEN_HI with err cleared.
- Latency: the 4th byte of a word is accepted at edge k; imem_we is high during cycle k..k+1; the next byte can be accepted at edge k+2 at the earliest.
- Throughput: one word per 5 cycles at full rate.
- start is ignored in LEN_HI, LEN_LO, DATA and WRITE.
- Bytes offered while rx_ready=0 are not consumed.
- Address arithmetic is 32-bit unsigned; with legal parameters the maximum address is BASE_ADDR+4*(DEPTH-1) and never wraps.
- Extra bytes after the final word are not accepted (rx_ready=0 in DONE).

Test Plan:
- Basic load:
  - Stimulus: start; bytes 00 02 | 20 08 00 05 | AC 08 00 04 at full rate; BASE_ADDR=0.
  - Required: two imem_we pulses: (addr 0x0, data 0x20080005), then (addr 0x4, data 0xAC080004).
  - Required: done=cpu_run=1 one cycle after the second pulse; busy=0.
- Backpressure/gaps:
  - Stimulus: same stream with rx_valid low for 3 cycles between every byte.
  - Required: identical writes and data; imem_we never high while a word is incomplete.
- Bad length:
  - Stimulus: header 00 00 -> err=1, cpu_run=0, no imem_we.
  - Stimulus: start, then header 00 41 with DEPTH=64 -> err=1, no writes.
- Reset mid-word:
  - Stimulus: after header 00 01 and bytes 12 34, drive RST_N=0 for one edge.
  - Required: all outputs at reset values; later bytes 56 78 produce no write; a fresh start + 00 01 + DE AD BE EF writes 0xDEADBEEF at addr 0.
- Start handling:
  - Stimulus: pulse start while in DATA.
  - Required: no effect; the load completes normally.
  - Stimulus: pulse start in DONE.
  - Required: cpu_run drops the next cycle and the new load overwrites from BASE_ADDR (set BASE_ADDR=0x100 in one run; first addr 0x100).
